score_judge: RTL and testbench
==============================

Name: score_judge

Overview:
- Receiving end of the dropper score interface: samples every dropper's score level once per frame and turns hit rising edges into points, combo and miss tallies.
- Owns the game-phase FSM (IDLE, PLAY, DONE), started and cleared by the same keycodes the droppers use.
- Outputs feed the score/combo text renderer and the colour mapper.

Parameters:
- N_DROPS, 32, number of dropper score inputs.
- SCORE_W, 16, width of the total score (saturating).
- COMBO_W, 8, width of the combo and max-combo counters (saturating).
- BASE_PTS, 10, points per hit.
- BONUS_PTS, 5, extra points per hit while the pre-update combo >= COMBO_TH.
- COMBO_TH, 10, combo threshold for the bonus.
- GRACE, 4, frames a key press may wait for a hit before counting as a miss.
- SONG_FRAMES, 4000, PLAY duration in frames.

Ports:
- frame_clk  in  1  frame-rate clock (one posedge per video frame).
- Reset_n  in  1  asynchronous active-low reset.
- keycode  in  8  primary USB keycode.
- keycode_second  in  8  secondary USB keycode.
- score  in  N_DROPS  level hit flags, one per dropper; high after a hit until that dropper halts.
- total_score  out  SCORE_W  accumulated points.
- combo  out  COMBO_W  current consecutive-hit count.
- max_combo  out  COMBO_W  best combo this song.
- hit_count  out  SCORE_W  total hits.
- miss_count  out  SCORE_W  total misses.
- game_state  out  2  0=IDLE, 1=PLAY, 2=DONE.
- hit_pulse  out  1  high for one frame when at least one hit is credited.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - All outputs 0; game_state=IDLE.
  - Internal score_prev, kc_prev, kc2_prev, grace counter and song counter all cleared.
  - Deassertion takes effect on the next posedge.
- All outputs are registered. An input change seen at posedge k is reflected in the outputs right after posedge k.
- Rising edges: rise = score & ~score_prev. score_prev <= score on every posedge, in every state.
- Key press event:
  - Fires for either slot when that slot is nonzero and differs from its previous-frame value.
  - 8'h2c and 8'h01 never count as press events.
- IDLE:
  - Counters hold their values, so the last results stay displayed.
  - keycode==8'h2c → PLAY. On that transition total_score, combo, max_combo, hit_count, miss_count, the song counter and the grace counter all clear to 0.
- PLAY:
  - Song counter increments each frame. When it reaches SONG_FRAMES-1 → DONE.
  - A hit in that final frame is still credited.
  - Let n = popcount(rise) and c = the combo value before this frame's update.
  - total_score += n*(BASE_PTS + (c >= COMBO_TH ? BONUS_PTS : 0)), saturating at all-ones.
  - hit_count += n, combo += n, both saturating.
  - max_combo <= max(max_combo, new combo).
  - hit_pulse = (n != 0).
  - Grace counter:
    - A press with n==0 loads GRACE if the counter is idle (0); a press while it is running does not reload it.
    - Any frame with n>0 clears the counter to 0.
    - Otherwise a nonzero counter decrements. The frame it goes 1→0 with no hit: combo <= 0, miss_count += 1.
    - Press and hit in the same frame: hit credited, counter not loaded.
- DONE:
  - Scoring frozen; rises and presses ignored; hit_pulse=0.
  - keycode==8'h01 → IDLE, with values held.
- 8'h2c in PLAY or DONE is ignored. 8'h01 in IDLE or PLAY is ignored.
- Reset mid-PLAY → IDLE with everything zeroed.

Test Plan:
- Reset_n low mid-PLAY → all outputs 0 and game_state=0 with no clock edge; after release, 8'h2c → game_state=1 on the next frame.
- PLAY, score[3] rises and holds high 5 frames → total_score=10, hit_count=1, combo=1, hit_pulse high for exactly 1 frame.
- score bits 0, 5 and 9 rise in the same frame with combo=10 → total_score += 45, combo=13, max_combo=13.
- Key 8'h07 pressed with no rise for 4 frames → combo drops to 0 and miss_count=1 on frame 4; rise on frame 3 instead → no miss, combo+1.
- total_score preloaded near 16'hFFFF, another hit → total_score=16'hFFFF (saturates, no wrap).
- Song counter reaches SONG_FRAMES-1 → DONE, later rises ignored; 8'h01 → IDLE with score held; 8'h2c → counters cleared.

Source files
------------

// File: rtl/score_judge.sv
// Score judge: samples the per-dropper hit levels once per frame, turns rising edges into
// points/combo/hit/miss tallies and runs the IDLE/PLAY/DONE game-phase FSM.
module score_judge #(
  parameter int N_DROPS     = 32,
  parameter int SCORE_W     = 16,
  parameter int COMBO_W     = 8,
  parameter int BASE_PTS    = 10,
  parameter int BONUS_PTS   = 5,
  parameter int COMBO_TH    = 10,
  parameter int GRACE       = 4,
  parameter int SONG_FRAMES = 4000
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic [7:0]         keycode,
  input  logic [7:0]         keycode_second,
  input  logic [N_DROPS-1:0] score,
  output logic [SCORE_W-1:0] total_score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic [SCORE_W-1:0] hit_count,
  output logic [SCORE_W-1:0] miss_count,
  output logic [1:0]         game_state,
  output logic               hit_pulse
);

  localparam int CNT_W   = $clog2(N_DROPS + 1);
  localparam int SONG_W  = $clog2(SONG_FRAMES);
  localparam int GRACE_W = $clog2(GRACE + 1);
  localparam logic [7:0]  KEY_START = 8'h2c;
  localparam logic [7:0]  KEY_BACK  = 8'h01;
  localparam logic [32:0] SCORE_MAX = (33'd1 << SCORE_W) - 33'd1;
  localparam logic [32:0] COMBO_MAX = (33'd1 << COMBO_W) - 33'd1;
  localparam logic [SCORE_W-1:0] ONE_S = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [N_DROPS-1:0]   score_prev;
  logic [7:0]           kc_prev, kc2_prev;
  logic [SONG_W-1:0]    song_cnt, song_d;
  logic [GRACE_W-1:0]   grace_cnt, grace_d;
  logic [SCORE_W-1:0]   total_d, hits_d, miss_d;
  logic [COMBO_W-1:0]   combo_d, max_d;
  logic                 pulse_d;

  logic [N_DROPS-1:0]   rise;
  logic [CNT_W-1:0]     n_rise;
  logic [31:0]          per_hit, pts;
  logic [32:0]          score_sum, hit_sum, combo_sum;
  logic [SCORE_W-1:0]   score_sat, hit_sat, miss_sat;
  logic [COMBO_W-1:0]   combo_sat;
  logic                 press, at_end;

  assign game_state = state_q;

  // Reserved keys (start/back) never count as a press on either slot.
  assign press = ((keycode != 8'h00) && (keycode != kc_prev) &&
                  (keycode != KEY_START) && (keycode != KEY_BACK)) ||
                 ((keycode_second != 8'h00) && (keycode_second != kc2_prev) &&
                  (keycode_second != KEY_START) && (keycode_second != KEY_BACK));
  assign at_end = (song_cnt == SONG_W'(SONG_FRAMES - 1));

  always_comb begin
    rise   = score & ~score_prev;
    n_rise = '0;
    for (int i = 0; i < N_DROPS; i++) n_rise = n_rise + CNT_W'(rise[i]);
  end

  // Bonus is decided by the combo before this frame's hits are added.
  always_comb begin
    per_hit   = (32'(combo) >= 32'(COMBO_TH)) ? 32'(BASE_PTS + BONUS_PTS) : 32'(BASE_PTS);
    pts       = 32'(n_rise) * per_hit;
    score_sum = 33'(total_score) + 33'(pts);
    hit_sum   = 33'(hit_count) + 33'(n_rise);
    combo_sum = 33'(combo) + 33'(n_rise);
    score_sat = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
    hit_sat   = (hit_sum > SCORE_MAX) ? '1 : hit_sum[SCORE_W-1:0];
    combo_sat = (combo_sum > COMBO_MAX) ? '1 : combo_sum[COMBO_W-1:0];
    miss_sat  = (miss_count == '1) ? miss_count : miss_count + ONE_S;
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (keycode == KEY_START) state_d = PLAY;
      PLAY:    if (at_end) state_d = DONE;
      DONE:    if (keycode == KEY_BACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    total_d = total_score;
    combo_d = combo;
    max_d   = max_combo;
    hits_d  = hit_count;
    miss_d  = miss_count;
    song_d  = song_cnt;
    grace_d = grace_cnt;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (keycode == KEY_START) begin
          total_d = '0;
          combo_d = '0;
          max_d   = '0;
          hits_d  = '0;
          miss_d  = '0;
          song_d  = '0;
          grace_d = '0;
        end
      end
      PLAY: begin
        song_d  = song_cnt + SONG_W'(1);
        total_d = score_sat;
        hits_d  = hit_sat;
        combo_d = combo_sat;
        max_d   = (combo_sat > max_combo) ? combo_sat : max_combo;
        pulse_d = (n_rise != '0);
        // A press opens a grace window; expiry without a hit breaks the combo.
        if (n_rise != '0) begin
          grace_d = '0;
        end else if (press && (grace_cnt == '0)) begin
          grace_d = GRACE_W'(GRACE);
        end else if (grace_cnt != '0) begin
          grace_d = grace_cnt - GRACE_W'(1);
          if (grace_cnt == GRACE_W'(1)) begin
            combo_d = '0;
            miss_d  = miss_sat;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_prev  <= '0;
      kc_prev     <= '0;
      kc2_prev    <= '0;
      song_cnt    <= '0;
      grace_cnt   <= '0;
      total_score <= '0;
      combo       <= '0;
      max_combo   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      hit_pulse   <= 1'b0;
    end else begin
      score_prev  <= score;
      kc_prev     <= keycode;
      kc2_prev    <= keycode_second;
      song_cnt    <= song_d;
      grace_cnt   <= grace_d;
      total_score <= total_d;
      combo       <= combo_d;
      max_combo   <= max_d;
      hit_count   <= hits_d;
      miss_count  <= miss_d;
      hit_pulse   <= pulse_d;
    end
  end

endmodule

// File: tb/tb_score_judge.sv
// Bench for score_judge: integer game model feeding an expected-output queue checked every
// frame, plus directed scenarios with hand-computed literal expectations.
module tb_score_judge;
  localparam int N_DROPS = 32, SCORE_W = 16, COMBO_W = 8, BASE_PTS = 10, BONUS_PTS = 5;
  localparam int COMBO_TH = 10, GRACE = 4, SONG_FRAMES = 4000;
  localparam int EW = 3 * SCORE_W + 2 * COMBO_W + 3;
  localparam int SMAX = (1 << SCORE_W) - 1;
  localparam int CMAX = (1 << COMBO_W) - 1;

  logic               frame_clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic [7:0]         keycode, keycode_second;
  logic [N_DROPS-1:0] score;
  logic [SCORE_W-1:0] total_score, hit_count, miss_count;
  logic [COMBO_W-1:0] combo, max_combo;
  logic [1:0]         game_state;
  logic               hit_pulse;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  int m_state, m_total, m_combo, m_max, m_hits, m_miss, m_grace, m_song, m_pulse;
  logic [31:0] m_sprev;
  logic [7:0]  m_kprev, m_k2prev;

  score_judge #(
    .N_DROPS(N_DROPS), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W), .BASE_PTS(BASE_PTS),
    .BONUS_PTS(BONUS_PTS), .COMBO_TH(COMBO_TH), .GRACE(GRACE), .SONG_FRAMES(SONG_FRAMES)
  ) dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
    .keycode_second(keycode_second), .score(score), .total_score(total_score),
    .combo(combo), .max_combo(max_combo), .hit_count(hit_count), .miss_count(miss_count),
    .game_state(game_state), .hit_pulse(hit_pulse)
  );

  // ---------------- clock ----------------
  always #5 frame_clk = ~frame_clk;

  // ---------------- model ----------------
  function automatic bit is_press(input logic [7:0] k, input logic [7:0] kp);
    return (k != 8'h00) && (k != kp) && (k != 8'h2c) && (k != 8'h01);
  endfunction

  task automatic model_reset();
    m_state = 0; m_total = 0; m_combo = 0; m_max = 0; m_hits = 0; m_miss = 0;
    m_grace = 0; m_song = 0; m_pulse = 0; m_sprev = '0; m_kprev = '0; m_k2prev = '0;
  endtask

  task automatic model_step();
    int n, per;
    bit press;
    n = $countones(score & ~m_sprev);
    press = is_press(keycode, m_kprev) || is_press(keycode_second, m_k2prev);
    m_pulse = 0;
    case (m_state)
      0: if (keycode == 8'h2c) begin
        m_state = 1; m_total = 0; m_combo = 0; m_max = 0; m_hits = 0; m_miss = 0;
        m_song = 0; m_grace = 0;
      end
      1: begin
        per = BASE_PTS + ((m_combo >= COMBO_TH) ? BONUS_PTS : 0);
        m_total = (m_total + n * per > SMAX) ? SMAX : m_total + n * per;
        m_hits  = (m_hits + n > SMAX) ? SMAX : m_hits + n;
        m_combo = (m_combo + n > CMAX) ? CMAX : m_combo + n;
        if (m_combo > m_max) m_max = m_combo;
        m_pulse = (n > 0);
        if (n > 0) m_grace = 0;
        else if (press && m_grace == 0) m_grace = GRACE;
        else if (m_grace > 0) begin
          m_grace--;
          if (m_grace == 0) begin
            m_combo = 0;
            if (m_miss < SMAX) m_miss++;
          end
        end
        if (m_song == SONG_FRAMES - 1) m_state = 2;
        m_song++;
      end
      default: if (keycode == 8'h01) m_state = 0;
    endcase
    m_sprev = score; m_kprev = keycode; m_k2prev = keycode_second;
  endtask

  always @(negedge Reset_n) model_reset();

  always @(posedge frame_clk) begin
    if (!Reset_n) model_reset();
    else model_step();
    exp_q.push_back({SCORE_W'(m_total), COMBO_W'(m_combo), COMBO_W'(m_max), SCORE_W'(m_hits),
                     SCORE_W'(m_miss), 2'(m_state), 1'(m_pulse)});
  end

  // ---------------- scoreboard ----------------
  always @(posedge frame_clk) begin
    logic [EW-1:0] got, want;
    #2;
    got = {total_score, combo, max_combo, hit_count, miss_count, game_state, hit_pulse};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL frame_cmp: expected queue empty at %0t, got %h", $time, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_errors++;
        $display("FAIL frame_cmp at %0t: got %h want %h", $time, got, want);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_total"}, total_score, 0);
    chk({tag, "_combo"}, combo, 0);
    chk({tag, "_max"}, max_combo, 0);
    chk({tag, "_hits"}, hit_count, 0);
    chk({tag, "_miss"}, miss_count, 0);
    chk({tag, "_state"}, game_state, 0);
    chk({tag, "_pulse"}, hit_pulse, 0);
  endtask

  // ---------------- driver ----------------
  task automatic frame(input logic [7:0] k, input logic [7:0] k2, input logic [31:0] s);
    keycode = k; keycode_second = k2; score = s;
    @(negedge frame_clk);
  endtask

  initial begin
    int guard, hits_before;
    keycode = '0; keycode_second = '0; score = '0;
    repeat (3) @(negedge frame_clk);
    chk_zero("reset");
    Reset_n = 1'b1;
    frame(8'h2c, 0, 0);
    chk("start_state", game_state, 1);
    frame(0, 0, 0);

    frame(0, 0, 32'h8);
    chk("hit1_pulse", hit_pulse, 1); chk("hit1_total", total_score, 10);
    chk("hit1_hits", hit_count, 1); chk("hit1_combo", combo, 1);
    frame(0, 0, 32'h8);
    chk("hold_pulse", hit_pulse, 0); chk("hold_total", total_score, 10);
    repeat (3) frame(0, 0, 32'h8);
    chk("hold5_hits", hit_count, 1); chk("hold5_pulse", hit_pulse, 0);
    frame(0, 0, 0);

    frame(0, 0, 32'h1ff);
    chk("nine_combo", combo, 10); chk("nine_total", total_score, 100);
    frame(0, 0, 0);
    frame(0, 0, 32'h221);
    chk("bonus_total", total_score, 145); chk("bonus_combo", combo, 13);
    chk("bonus_max", max_combo, 13);
    frame(0, 0, 0);

    frame(8'h07, 0, 0);
    repeat (3) frame(8'h07, 0, 0);
    chk("grace3_miss", miss_count, 0); chk("grace3_combo", combo, 13);
    frame(8'h07, 0, 0);
    chk("miss_count", miss_count, 1); chk("miss_combo", combo, 0);
    chk("miss_max", max_combo, 13);
    frame(0, 0, 0);

    frame(8'h07, 0, 0); frame(8'h07, 0, 0); frame(8'h07, 0, 0);
    frame(8'h07, 0, 32'h2);
    chk("rescue_combo", combo, 1); chk("rescue_total", total_score, 155);
    repeat (5) frame(8'h07, 0, 32'h2);
    chk("rescue_miss", miss_count, 1);
    frame(0, 0, 0);

    frame(0, 8'h04, 32'h4);
    chk("presshit_combo", combo, 2);
    repeat (5) frame(0, 8'h04, 32'h4);
    chk("presshit_miss", miss_count, 1);
    frame(8'h2c, 0, 0); frame(8'h01, 0, 0);
    chk("play_keys_state", game_state, 1); chk("play_keys_total", total_score, 165);
    frame(0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      frame(0, 0, 32'hffff_ffff);
      frame(0, 0, 0);
    end
    chk("sat_total", total_score, 16'hffff); chk("sat_combo", combo, 255);
    chk("sat_max", max_combo, 255);

    guard = 0;
    while (m_song != SONG_FRAMES - 1 && guard < 5000) begin
      frame(0, 0, 0);
      guard++;
    end
    if (guard >= 5000) begin
      n_checks++; n_errors++;
      $display("FAIL song_end_wait: bound of %0d frames expired", guard);
    end
    hits_before = m_hits;
    frame(0, 0, 32'h0010_0000);
    chk("last_state", game_state, 2); chk("last_pulse", hit_pulse, 1);
    chk("last_hits", hit_count, hits_before + 1);
    frame(0, 0, 0);
    frame(0, 0, 32'h0020_0000);
    chk("done_pulse", hit_pulse, 0); chk("done_hits", hit_count, hits_before + 1);
    frame(8'h2c, 0, 0);
    chk("done_start_ign", game_state, 2);
    frame(8'h01, 0, 0);
    chk("back_state", game_state, 0); chk("back_total", total_score, 16'hffff);
    frame(0, 0, 0);
    frame(8'h2c, 0, 0);
    chk("restart_state", game_state, 1); chk("restart_total", total_score, 0);
    chk("restart_hits", hit_count, 0); chk("restart_max", max_combo, 0);
    frame(0, 0, 0);
    frame(0, 0, 32'h1);
    chk("restart_hit", total_score, 10);

    #2 Reset_n = 1'b0;
    #1 chk_zero("async");
    @(negedge frame_clk); @(negedge frame_clk);
    Reset_n = 1'b1;
    frame(8'h2c, 0, 0);
    chk("post_reset_state", game_state, 1);
    frame(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
